// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan path: hex segment patterns (abcdefg, 1=lit),
// segment bit positions, the scan-decoder state encoding and the input sample record.
package display_pkg;

   localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
   localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
   localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
   localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
   localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
   localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
   localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
   localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
   localparam logic [6:0] SEG_HEX_A = 7'b1110111;
   localparam logic [6:0] SEG_HEX_B = 7'b0011111;
   localparam logic [6:0] SEG_HEX_C = 7'b1001110;
   localparam logic [6:0] SEG_HEX_D = 7'b0111101;
   localparam logic [6:0] SEG_HEX_E = 7'b1001111;
   localparam logic [6:0] SEG_HEX_F = 7'b1000111;

   // All segments dark, in the active-high domain.
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   localparam int SEG_IDX_A = 6;
   localparam int SEG_IDX_B = 5;
   localparam int SEG_IDX_C = 4;
   localparam int SEG_IDX_D = 3;
   localparam int SEG_IDX_E = 2;
   localparam int SEG_IDX_F = 1;
   localparam int SEG_IDX_G = 0;

   localparam logic [1:0] ST_BLANK  = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

   typedef struct packed {
      logic [6:0] seg_l;
      logic       dp_l;
      logic [3:0] dig;
   } scan_smp_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to hex decoder; unknown patterns (including all-off)
// return nibble 0 with bad set.
module seg7_decode
   import display_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       bad
);

   always_comb begin
      nibble = 4'h0;
      bad    = 1'b0;
      case (pattern)
         SEG_HEX_0: nibble = 4'h0;
         SEG_HEX_1: nibble = 4'h1;
         SEG_HEX_2: nibble = 4'h2;
         SEG_HEX_3: nibble = 4'h3;
         SEG_HEX_4: nibble = 4'h4;
         SEG_HEX_5: nibble = 4'h5;
         SEG_HEX_6: nibble = 4'h6;
         SEG_HEX_7: nibble = 4'h7;
         SEG_HEX_8: nibble = 4'h8;
         SEG_HEX_9: nibble = 4'h9;
         SEG_HEX_A: nibble = 4'hA;
         SEG_HEX_B: nibble = 4'hB;
         SEG_HEX_C: nibble = 4'hC;
         SEG_HEX_D: nibble = 4'hD;
         SEG_HEX_E: nibble = 4'hE;
         SEG_HEX_F: nibble = 4'hF;
         SEG_OFF:   bad    = 1'b1;
         default:   bad    = 1'b1;
      endcase
   end

endmodule

// File: rtl/display_scan_decoder.sv
// Monitors a multiplexed 7-segment scan, captures each settled digit and
// publishes a four-digit frame with a one-cycle strobe.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// BLANK     | no single digit selected (or capture disabled)
// SETTLE    | one digit selected, waiting for SETTLE_CYC stable cycles
// HELD      | digit captured; waits for select or segments to change
module display_scan_decoder
   import display_pkg::*;
#(
   parameter int   SETTLE_CYC = 4,
   parameter logic DIG_ACT    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [6:0]  seg_l,
   input  logic        dp_l,
   input  logic [3:0]  dig,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic [3:0]  dps,
   output logic [3:0]  bad_seg,
   output logic        frame_stb,
   output logic        changed,
   output logic        onehot_err
);

   // Down-counter reload; terminal count 0 marks the SETTLE_CYC-th stable cycle.
   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   scan_smp_t   smp_s_q, smp_s_d;
   scan_smp_t   smp_p_q, smp_p_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] buf_nib_q, buf_nib_d;
   logic [3:0]  buf_dp_q, buf_dp_d;
   logic [3:0]  buf_bad_q, buf_bad_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  dps_q, dps_d;
   logic [3:0]  bad_seg_q, bad_seg_d;
   logic        frame_stb_q, frame_stb_d;
   logic        changed_q, changed_d;
   logic        onehot_err_q, onehot_err_d;
   logic        first_q, first_d;

   logic [3:0]  sel;
   logic        sel_multi;
   logic        sel_one;
   logic        stable;
   logic        capture;
   logic [6:0]  seg_act;
   logic [3:0]  dec_nib;
   logic        dec_bad;
   logic [3:0]  mask_nx;

   assign sel       = smp_s_q.dig ^ {4{~DIG_ACT}};
   assign sel_multi = (sel & (sel - 4'd1)) != 4'd0;
   assign sel_one   = (sel != 4'd0) && !sel_multi;
   assign stable    = (smp_s_q == smp_p_q);
   assign seg_act   = ~smp_s_q.seg_l;

   seg7_decode u_seg7_decode (
      .pattern (seg_act),
      .nibble  (dec_nib),
      .bad     (dec_bad)
   );

   always_comb begin
      smp_s_d = '{seg_l: seg_l, dp_l: dp_l, dig: dig};
      smp_p_d = smp_s_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!en || !sel_one) begin
         state_d = ST_BLANK;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            ST_BLANK: begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_LOAD;
            end
            ST_SETTLE: begin
               if (!stable) begin
                  cnt_d = CNT_LOAD;
               end else if (cnt_q == 8'd0) begin
                  capture = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_HELD: begin
               if (!stable) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CNT_LOAD;
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      mask_nx     = mask_q;
      mask_d      = mask_q;
      buf_nib_d   = buf_nib_q;
      buf_dp_d    = buf_dp_q;
      buf_bad_d   = buf_bad_q;
      digits_d    = digits_q;
      dps_d       = dps_q;
      bad_seg_d   = bad_seg_q;
      changed_d   = changed_q;
      first_d     = first_q;
      frame_stb_d = 1'b0;
      if (!en) begin
         mask_d = 4'd0;
      end else begin
         // Frame publishes one cycle after the fourth slot write.
         if (mask_q == 4'hF) begin
            digits_d    = buf_nib_q;
            dps_d       = buf_dp_q;
            bad_seg_d   = buf_bad_q;
            frame_stb_d = 1'b1;
            changed_d   = first_q ||
                          ({buf_nib_q, buf_dp_q, buf_bad_q} != {digits_q, dps_q, bad_seg_q});
            first_d     = 1'b0;
            mask_nx     = 4'd0;
         end
         if (capture) begin
            mask_nx = mask_nx | sel;
            for (int i = 0; i < 4; i++) begin
               if (sel[i]) begin
                  buf_nib_d[4*i +: 4] = dec_nib;
                  buf_dp_d[i]         = ~smp_s_q.dp_l;
                  buf_bad_d[i]        = dec_bad;
               end
            end
         end
         mask_d = mask_nx;
      end
   end

   // A new multi-hot detection takes priority over a clear in the same cycle.
   always_comb begin
      onehot_err_d = onehot_err_q;
      if (sel_multi) begin
         onehot_err_d = 1'b1;
      end else if (err_clr) begin
         onehot_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         smp_s_q      <= '0;
         smp_p_q      <= '0;
         state_q      <= ST_BLANK;
         cnt_q        <= 8'd0;
         mask_q       <= 4'd0;
         buf_nib_q    <= 16'd0;
         buf_dp_q     <= 4'd0;
         buf_bad_q    <= 4'd0;
         digits_q     <= 16'd0;
         dps_q        <= 4'd0;
         bad_seg_q    <= 4'd0;
         frame_stb_q  <= 1'b0;
         changed_q    <= 1'b0;
         onehot_err_q <= 1'b0;
         first_q      <= 1'b1;
      end else begin
         smp_s_q      <= smp_s_d;
         smp_p_q      <= smp_p_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         buf_nib_q    <= buf_nib_d;
         buf_dp_q     <= buf_dp_d;
         buf_bad_q    <= buf_bad_d;
         digits_q     <= digits_d;
         dps_q        <= dps_d;
         bad_seg_q    <= bad_seg_d;
         frame_stb_q  <= frame_stb_d;
         changed_q    <= changed_d;
         onehot_err_q <= onehot_err_d;
         first_q      <= first_d;
      end
   end

   assign digits     = digits_q;
   assign dps        = dps_q;
   assign bad_seg    = bad_seg_q;
   assign frame_stb  = frame_stb_q;
   assign changed    = changed_q;
   assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: scans active-low digit patterns and
// checks frame contents, strobe timing, change flag, errors, reset and enable.
module tb_display_scan_decoder;

   localparam logic [6:0] L1   = 7'b1001111;
   localparam logic [6:0] L2   = 7'b0010010;
   localparam logic [6:0] L3   = 7'b0000110;
   localparam logic [6:0] L4   = 7'b1001100;
   localparam logic [6:0] L5   = 7'b0100100;
   localparam logic [6:0] L6   = 7'b0100000;
   localparam logic [6:0] L7   = 7'b0001111;
   localparam logic [6:0] L8   = 7'b0000000;
   localparam logic [6:0] L9   = 7'b0000100;
   localparam logic [6:0] LA   = 7'b0001000;
   localparam logic [6:0] LB   = 7'b1100000;
   localparam logic [6:0] LC   = 7'b0110001;
   localparam logic [6:0] LF   = 7'b0111000;
   localparam logic [6:0] LBAD = 7'b1010101;

   logic        clk;
   logic        rst;
   logic        en;
   logic [6:0]  seg_l;
   logic        dp_l;
   logic [3:0]  dig;
   logic        err_clr;
   logic [15:0] digits;
   logic [3:0]  dps;
   logic [3:0]  bad_seg;
   logic        frame_stb;
   logic        changed;
   logic        onehot_err;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   int snap;

   display_scan_decoder #(.SETTLE_CYC(4), .DIG_ACT(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .seg_l      (seg_l),
      .dp_l       (dp_l),
      .dig        (dig),
      .err_clr    (err_clr),
      .digits     (digits),
      .dps        (dps),
      .bad_seg    (bad_seg),
      .frame_stb  (frame_stb),
      .changed    (changed),
      .onehot_err (onehot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_stb === 1'b1) stb_cnt = stb_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] d, input logic [6:0] s, input logic p, input int n);
      dig   = d;
      seg_l = s;
      dp_l  = p;
      tick(n);
   endtask

   task automatic scan(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                       input logic [6:0] s4, input logic [3:0] dpl, input int dwell);
      drive(4'b1000, s1, dpl[3], dwell);
      drive(4'b0100, s2, dpl[2], dwell);
      drive(4'b0010, s3, dpl[1], dwell);
      drive(4'b0001, s4, dpl[0], dwell);
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; seg_l = 7'h7F; dp_l = 1'b1; dig = 4'b0000; err_clr = 1'b0;
      tick(3);
      check("rst_digits", digits, 16'h0000);
      check("rst_dps", {12'd0, dps}, 16'h0);
      check("rst_bad", {12'd0, bad_seg}, 16'h0);
      check("rst_stb", {15'd0, frame_stb}, 16'h0);
      check("rst_changed", {15'd0, changed}, 16'h0);
      check("rst_err", {15'd0, onehot_err}, 16'h0);
      rst = 1'b1;
      tick(2);

      // First frame: strobe exactly one cycle after the fourth dwell ends.
      scan(L1, L2, L3, L4, 4'b1111, 6);
      check("f1_stb_early", {15'd0, frame_stb}, 16'h0);
      tick(1);
      check("f1_stb", {15'd0, frame_stb}, 16'h1);
      check("f1_digits", digits, 16'h1234);
      check("f1_bad", {12'd0, bad_seg}, 16'h0);
      check("f1_dps", {12'd0, dps}, 16'h0);
      check("f1_changed", {15'd0, changed}, 16'h1);
      tick(1);
      check("f1_stb_pulse", {15'd0, frame_stb}, 16'h0);

      scan(L1, L2, L3, L4, 4'b1111, 6);
      tick(1);
      check("f2_stb", {15'd0, frame_stb}, 16'h1);
      check("f2_digits", digits, 16'h1234);
      check("f2_changed", {15'd0, changed}, 16'h0);

      scan(L1, L2, L3, LF, 4'b1111, 6);
      tick(1);
      check("f3_stb", {15'd0, frame_stb}, 16'h1);
      check("f3_digits", digits, 16'h123F);
      check("f3_changed", {15'd0, changed}, 16'h1);

      // Short dwell on dig2 leaves slot 2 empty until a full dwell arrives.
      tick(2);
      snap = stb_cnt;
      drive(4'b1000, L9, 1'b1, 6);
      drive(4'b0100, L8, 1'b1, 3);
      drive(4'b0010, L7, 1'b1, 6);
      drive(4'b0001, L6, 1'b1, 6);
      drive(4'b0000, 7'h7F, 1'b1, 4);
      check("short_no_stb", 16'(stb_cnt - snap), 16'd0);
      drive(4'b0100, L5, 1'b1, 6);
      tick(1);
      check("short_stb", {15'd0, frame_stb}, 16'h1);
      check("short_digits", digits, 16'h9576);
      tick(2);
      check("short_stb_cnt", 16'(stb_cnt - snap), 16'd1);

      scan(LBAD, L2, L3, L4, 4'b1101, 6);
      tick(1);
      check("bad_stb", {15'd0, frame_stb}, 16'h1);
      check("bad_digits", digits, 16'h0234);
      check("bad_mask", {12'd0, bad_seg}, 16'h8);
      check("bad_dps", {12'd0, dps}, 16'h2);

      // Multi-hot select is sticky across later frames.
      drive(4'b1100, L1, 1'b1, 1);
      drive(4'b0000, 7'h7F, 1'b1, 2);
      check("oh_set", {15'd0, onehot_err}, 16'h1);
      scan(L1, L2, L3, L4, 4'b1111, 6);
      tick(1);
      check("oh_frame_digits", digits, 16'h1234);
      check("oh_sticky", {15'd0, onehot_err}, 16'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      check("oh_clr", {15'd0, onehot_err}, 16'h0);
      drive(4'b1100, L1, 1'b1, 1);
      dig = 4'b0000;
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      check("oh_set_wins", {15'd0, onehot_err}, 16'h1);

      // Reset mid-frame discards the partial captures.
      drive(4'b1000, LA, 1'b1, 6);
      drive(4'b0100, LB, 1'b1, 6);
      drive(4'b0010, LC, 1'b1, 6);
      rst = 1'b0;
      tick(2);
      check("mid_rst_digits", digits, 16'h0000);
      check("mid_rst_err", {15'd0, onehot_err}, 16'h0);
      rst = 1'b1;
      drive(4'b0000, 7'h7F, 1'b1, 2);
      snap = stb_cnt;
      scan(L1, L2, L3, L4, 4'b1111, 6);
      tick(1);
      check("post_rst_stb", {15'd0, frame_stb}, 16'h1);
      check("post_rst_digits", digits, 16'h1234);
      check("post_rst_changed", {15'd0, changed}, 16'h1);
      tick(2);
      check("post_rst_stb_cnt", 16'(stb_cnt - snap), 16'd1);

      // Capture disabled: no frame and outputs hold.
      en = 1'b0;
      snap = stb_cnt;
      scan(L5, L6, L7, L8, 4'b0000, 6);
      tick(3);
      check("en_off_stb_cnt", 16'(stb_cnt - snap), 16'd0);
      check("en_off_digits", digits, 16'h1234);
      check("en_off_dps", {12'd0, dps}, 16'h0);
      en = 1'b1;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/display_scan_decoder.md
Name: display_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment scan produced by display_driver.
- Samples the active-low segment lines and the digit-select lines, waits for each digit dwell to settle, and decodes each segment pattern back to a hex nibble.
- Assembles the four nibbles into a frame and raises a one-cycle frame strobe.
- Used on-chip as a self-check/loopback monitor and as a bench scoreboard front end.

Parameters:
- SETTLE_CYC, 4: cycles a single digit must stay selected with unchanged segments before capture; range 1..255.
- DIG_ACT, 1'b1: active level of the dig[3:0] inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  capture enable; low clears the settle counter and the capture mask, outputs hold.
- seg_l  in  7  segments a..g, active-low; seg_l[6]=a … seg_l[0]=g.
- dp_l  in  1  decimal point, active-low.
- dig  in  4  digit selects; dig[3]=dig1 (leftmost) … dig[0]=dig4.
- err_clr  in  1  clears onehot_err.
- digits  out  16  last complete frame; [15:12]=dig1 … [3:0]=dig4.
- dps  out  4  decimal point per digit, 1=lit, same ordering as dig.
- bad_seg  out  4  1 = the captured pattern for that digit was not in the hex table.
- frame_stb  out  1  one-cycle pulse when a new frame loads.
- changed  out  1  valid with frame_stb; 1 if {digits,dps,bad_seg} differs from the previous frame.
- onehot_err  out  1  sticky; multiple digits were selected simultaneously.

Behaviour:
- Reset (rst=0, async): digits=0, dps=0, bad_seg=0, frame_stb=0, changed=0, onehot_err=0, internal registers cleared. The first frame after reset reports changed=1.
- Input stage: seg_l, dp_l and dig are registered once (stage S). All further decisions use S and the previous S (stage P).
- Selection: let sel = (S.dig == {4{DIG_ACT}}) ? … per bit, i.e. sel = active-normalized dig.
  - Exactly one bit set → IDLE/DWELL logic below.
  - Zero bits set → blanking: counter cleared, dwell_done cleared.
  - Two or more bits set → same as zero bits, and onehot_err is set the next cycle.
- Per-digit state machine (states BLANK, SETTLE, HELD):
  - BLANK → SETTLE when one-hot sel appears; counter=1.
  - SETTLE: if sel, seg_l and dp_l all equal P, increment the counter; otherwise restart counter=1 (on a new digit) or go to BLANK.
  - SETTLE → HELD when counter==SETTLE_CYC. On that cycle, write the nibble, dp and bad bit into the slot selected by sel and set mask[slot].
  - HELD: no further capture until sel or the segments change. On change, go to SETTLE, or BLANK if sel is not one-hot.
- Decode table, abcdefg with 1=lit:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Any other pattern (including all-off) → nibble 0, bad bit 1.
- Frame assembly:
  - When the mask reaches 4'b1111 (checked after the capture write), the next cycle does all of the following: pulse frame_stb; load digits/dps/bad_seg from the slot buffers; compute changed against the previous outputs; clear the mask.
  - A slot recaptured before the frame completes overwrites its buffer (last value wins).
- Latency: SETTLE_CYC+2 cycles from the first stable one-hot dig edge to the slot write. frame_stb follows the fourth slot write by 1 cycle.
- en=0: counter and mask forced to 0, state forced to BLANK, outputs hold. onehot_err detection stays active.
- err_clr: clears onehot_err. If err_clr and a new multi-hot detection occur in the same cycle, the set wins.
- Reset mid-frame: all partial captures are discarded.

Decomposition:
- Package display_pkg holds:
  - localparams for the 16 segment patterns;
  - segment bit indices A..G;
  - the SEG_OFF constant;
  - the state encoding BLANK/SETTLE/HELD.
- Sub-module seg7_decode: purely combinational, 7-bit active-high pattern → {bad, nibble[3:0]}. It is reusable by display_driver tests.

Test Plan:
- Reset then scan: dig rotates 1000→0100→0010→0001, 6 cycles each, showing "1","2","3","4", DIG_ACT=1, SETTLE_CYC=4 → frame_stb once; digits=16'h1234, bad_seg=0, changed=1.
- Repeat the same scan → second frame_stb with changed=0. Then change dig4 to "F" (seg_l=7'b0111000) → digits=16'h123F, changed=1.
- Dwell of only 3 cycles on dig2 → no capture for slot 2, no frame_stb until a full-length dwell occurs.
- seg_l=7'b1010101 on dig1 → bad_seg[3]=1 and digits[15:12]=0. Also dp_l=0 on dig3 → dps=4'b0010.
- dig=4'b1100 for one cycle → onehot_err=1 and stays 1 through later valid frames. err_clr pulse → 0. err_clr coinciding with multi-hot → stays 1.
- Assert rst after three slots are captured, then release, then do a full scan → exactly one frame_stb and no stale data. en=0 during the scan → no frame_stb and outputs unchanged.
